// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating icache line fills and data accesses
module mem_ctrl #(
    parameter int         BLOCK_WIDTH = 4,
    parameter logic [1:0] IO_HI       = 2'b11
) (
    input  logic                          clkIn,
    input  logic                          resetIn,
    input  logic [7:0]                    memDin,
    output logic [7:0]                    memDout,
    output logic [31:0]                   memAddr,
    output logic                          memWr,
    input  logic                          ioBufferFull,
    input  logic                          instrMiss,
    input  logic [31-BLOCK_WIDTH:0]       instrAddr,
    output logic                          icacheValid,
    output logic [31-BLOCK_WIDTH:0]       icacheAddr,
    output logic [8*(2**BLOCK_WIDTH)-1:0] icacheData,
    input  logic                          dataReq,
    input  logic                          dataWrite,
    input  logic [1:0]                    dataSize,
    input  logic [31:0]                   dataAddr,
    input  logic [31:0]                   dataIn,
    output logic                          dataDone,
    output logic [31:0]                   dataOut
);

    localparam int             LINE  = 2**BLOCK_WIDTH;
    localparam int             CW    = BLOCK_WIDTH + 1;
    localparam logic [CW-1:0]  ONE   = CW'(1);
    localparam logic [CW-1:0]  NLINE = CW'(LINE);

    typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

    state_t                    state_q;
    logic                      last_grant_q;
    logic [CW-1:0]             k_q;
    logic [CW-1:0]             n_q;
    logic [31:0]               base_q;
    logic [31:0]               wdata_q;
    logic [31:0]               mem_addr_q;
    logic [7:0]                mem_dout_q;
    logic                      icache_valid_q;
    logic [31-BLOCK_WIDTH:0]   icache_addr_q;
    logic [8*LINE-1:0]         icache_data_q;
    logic                      data_done_q;
    logic [31:0]               data_out_q;

    logic [CW-1:0]             k_inc;
    logic [BLOCK_WIDTH-1:0]    cap_idx;
    logic [CW-1:0]             size_n;
    logic                      stall;

    assign k_inc   = k_q + ONE;
    // Byte captured this cycle is the one whose address went out last cycle.
    assign cap_idx = k_q[BLOCK_WIDTH-1:0] - ONE[BLOCK_WIDTH-1:0];
    assign stall   = (mem_addr_q[17:16] == IO_HI) && ioBufferFull;

    // Decode access size; the illegal code 11 behaves as a word.
    always_comb begin
        size_n = CW'(4);
        case (dataSize)
            2'b00:   size_n = CW'(1);
            2'b01:   size_n = CW'(2);
            default: size_n = CW'(4);
        endcase
    end

    // Arbitration, byte sequencing, assembly and completion pulses.
    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            k_q            <= '0;
            n_q            <= '0;
            base_q         <= '0;
            wdata_q        <= '0;
            mem_addr_q     <= '0;
            mem_dout_q     <= '0;
            icache_valid_q <= 1'b0;
            icache_addr_q  <= '0;
            icache_data_q  <= '0;
            data_done_q    <= 1'b0;
            data_out_q     <= '0;
        end else begin
            icache_valid_q <= 1'b0;
            data_done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dataReq && (!instrMiss || last_grant_q)) begin
                        base_q       <= dataAddr;
                        mem_addr_q   <= dataAddr;
                        n_q          <= size_n;
                        wdata_q      <= dataIn;
                        mem_dout_q   <= dataIn[7:0];
                        data_out_q   <= '0;
                        k_q          <= '0;
                        last_grant_q <= 1'b0;
                        state_q      <= dataWrite ? DWRITE : DREAD;
                    end else if (instrMiss) begin
                        base_q        <= {instrAddr, {BLOCK_WIDTH{1'b0}}};
                        mem_addr_q    <= {instrAddr, {BLOCK_WIDTH{1'b0}}};
                        n_q           <= NLINE;
                        icache_addr_q <= instrAddr;
                        k_q           <= '0;
                        last_grant_q  <= 1'b1;
                        state_q       <= IFETCH;
                    end
                end
                IFETCH, DREAD: begin
                    if (k_q != '0) begin
                        if (state_q == IFETCH)
                            icache_data_q[{cap_idx, 3'b000} +: 8] <= memDin;
                        else
                            data_out_q[{cap_idx[1:0], 3'b000} +: 8] <= memDin;
                    end
                    if (k_q == n_q) begin
                        state_q <= DONE;
                        if (state_q == IFETCH)
                            icache_valid_q <= 1'b1;
                        else
                            data_done_q <= 1'b1;
                    end else begin
                        k_q <= k_inc;
                        if (k_inc < n_q)
                            mem_addr_q <= base_q + {{(32-CW){1'b0}}, k_inc};
                    end
                end
                DWRITE: begin
                    if (!stall) begin
                        if (k_inc == n_q) begin
                            state_q     <= DONE;
                            data_done_q <= 1'b1;
                        end else begin
                            k_q        <= k_inc;
                            mem_addr_q <= base_q + {{(32-CW){1'b0}}, k_inc};
                            mem_dout_q <= wdata_q[{k_inc[1:0], 3'b000} +: 8];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign memWr       = (state_q == DWRITE) && !stall;
    assign memAddr     = mem_addr_q;
    assign memDout     = mem_dout_q;
    assign icacheValid = icache_valid_q;
    assign icacheAddr  = icache_addr_q;
    assign icacheData  = icache_data_q;
    assign dataDone    = data_done_q;
    assign dataOut     = data_out_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    localparam int BW   = 4;
    localparam int MAXC = 512;

    logic              clkIn = 1'b0;
    logic              resetIn;
    logic [7:0]        memDin;
    logic [7:0]        memDout;
    logic [31:0]       memAddr;
    logic              memWr;
    logic              ioBufferFull;
    logic              instrMiss;
    logic [31-BW:0]    instrAddr;
    logic              icacheValid;
    logic [31-BW:0]    icacheAddr;
    logic [127:0]      icacheData;
    logic              dataReq;
    logic              dataWrite;
    logic [1:0]        dataSize;
    logic [31:0]       dataAddr;
    logic [31:0]       dataIn;
    logic              dataDone;
    logic [31:0]       dataOut;

    mem_ctrl #(.BLOCK_WIDTH(BW), .IO_HI(2'b11)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .memDin(memDin), .memDout(memDout),
        .memAddr(memAddr), .memWr(memWr), .ioBufferFull(ioBufferFull),
        .instrMiss(instrMiss), .instrAddr(instrAddr), .icacheValid(icacheValid),
        .icacheAddr(icacheAddr), .icacheData(icacheData), .dataReq(dataReq),
        .dataWrite(dataWrite), .dataSize(dataSize), .dataAddr(dataAddr),
        .dataIn(dataIn), .dataDone(dataDone), .dataOut(dataOut)
    );

    always #5 clkIn = ~clkIn;

    logic [7:0] ram [0:262143];

    always @(posedge clkIn) begin
        memDin <= ram[memAddr[17:0]];
        if (memWr === 1'b1) ram[memAddr[17:0]] <= memDout;
    end

    int cyc = 0;
    always @(posedge clkIn) cyc = cyc + 1;

    logic          mw   [0:MAXC-1];
    logic [31:0]   ma   [0:MAXC-1];
    logic [7:0]    md   [0:MAXC-1];
    logic          iv   [0:MAXC-1];
    logic          dd   [0:MAXC-1];
    logic [31:0]   dout [0:MAXC-1];
    logic [127:0]  idat [0:MAXC-1];
    logic [31-BW:0] iadr [0:MAXC-1];

    always @(negedge clkIn) begin
        if (cyc < MAXC) begin
            mw[cyc]   = memWr;
            ma[cyc]   = memAddr;
            md[cyc]   = memDout;
            iv[cyc]   = icacheValid;
            dd[cyc]   = dataDone;
            dout[cyc] = dataOut;
            idat[cyc] = icacheData;
            iadr[cyc] = icacheAddr;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clkIn);
        #1;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    function automatic int count_hi(input int which, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (which)
                0:       if (iv[i] === 1'b1) n++;
                1:       if (dd[i] === 1'b1) n++;
                default: if (mw[i] === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    int t;
    int t2;

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            ram[32'h1230 + i] = 8'(i);
            ram[32'h1240 + i] = 8'(8'hA0 + i);
        end
        ram[32'h1003] = 8'h78;
        ram[32'h1004] = 8'h56;
        ram[32'h1005] = 8'h34;
        ram[32'h1006] = 8'h12;

        // Reset with both requests pending.
        resetIn = 1'b0; dataReq = 1'b1; instrMiss = 1'b1; dataWrite = 1'b0;
        dataSize = 2'b10; dataAddr = 32'h1003; dataIn = 32'h0; ioBufferFull = 1'b0;
        instrAddr = 28'h0000123;
        next_cycle();
        next_cycle();
        @(negedge clkIn);
        check("rst_addr", memAddr, 0);
        check("rst_dout", memDout, 0);
        check("rst_wr", memWr, 0);
        check("rst_iv", icacheValid, 0);
        check("rst_iadr", icacheAddr, 0);
        check("rst_idat", icacheData, 0);
        check("rst_dd", dataDone, 0);
        check("rst_dout32", dataOut, 0);

        // Release; both held: ifetch, data, ifetch, data.
        next_cycle();
        resetIn = 1'b1;
        t = cyc;
        run_until(t + 52);
        dataReq = 1'b0; instrMiss = 1'b0;
        check("rst_wr_seen", count_hi(2, 1, t), 0);
        for (int k = 0; k < 16; k++)
            check($sformatf("if_addr%0d", k), ma[t + 1 + k], 32'h1230 + k);
        check("if_iv_early", count_hi(0, t, t + 17), 0);
        check("if_iv", iv[t + 18], 1);
        check("if_iadr", iadr[t + 18], 28'h0000123);
        check("if_idat", idat[t + 18], 128'h0f0e0d0c0b0a09080706050403020100);
        for (int k = 0; k < 4; k++)
            check($sformatf("wl_addr%0d", k), ma[t + 20 + k], 32'h1003 + k);
        check("wl_dd", dd[t + 25], 1);
        check("wl_dout", dout[t + 25], 32'h12345678);
        check("alt_iv2", iv[t + 44], 1);
        check("alt_dd2", dd[t + 51], 1);
        check("alt_iv_cnt", count_hi(0, t, t + 51), 2);
        check("alt_dd_cnt", count_hi(1, t, t + 51), 2);
        check("rd_no_wr", count_hi(2, t, t + 51), 0);

        // Half load.
        next_cycle();
        dataReq = 1'b1; dataSize = 2'b01; dataAddr = 32'h1003;
        t = cyc;
        run_until(t + 5);
        dataReq = 1'b0;
        check("hl_dd_early", dd[t + 3], 0);
        check("hl_dd", dd[t + 4], 1);
        check("hl_dout", dout[t + 4], 32'h00005678);

        // Byte load.
        next_cycle();
        dataReq = 1'b1; dataSize = 2'b00; dataAddr = 32'h1006;
        t = cyc;
        run_until(t + 4);
        dataReq = 1'b0;
        check("bl_dd", dd[t + 3], 1);
        check("bl_dout", dout[t + 3], 32'h00000012);

        // Byte store to I/O region with buffer full for three cycles.
        next_cycle();
        dataReq = 1'b1; dataWrite = 1'b1; dataSize = 2'b00;
        dataAddr = 32'h00030000; dataIn = 32'h000000AB;
        t = cyc;
        next_cycle();
        ioBufferFull = 1'b1;
        run_until(t + 4);
        ioBufferFull = 1'b0;
        run_until(t + 6);
        dataReq = 1'b0;
        check("io_stall_wr", count_hi(2, t + 1, t + 3), 0);
        check("io_wr", mw[t + 4], 1);
        check("io_addr", ma[t + 4], 32'h00030000);
        check("io_data", md[t + 4], 8'hAB);
        check("io_dd_early", dd[t + 4], 0);
        check("io_dd", dd[t + 5], 1);
        check("io_wr_cnt", count_hi(2, t, t + 5), 1);
        check("io_ram", ram[18'h30000], 8'hAB);

        // Half store crossing into the I/O region: only the second byte stalls.
        next_cycle();
        dataReq = 1'b1; dataSize = 2'b01; dataAddr = 32'h0002FFFF; dataIn = 32'h0000BEEF;
        t = cyc;
        next_cycle();
        ioBufferFull = 1'b1;
        run_until(t + 3);
        ioBufferFull = 1'b0;
        run_until(t + 5);
        dataReq = 1'b0; dataWrite = 1'b0;
        check("hs_wr0", mw[t + 1], 1);
        check("hs_addr0", ma[t + 1], 32'h0002FFFF);
        check("hs_data0", md[t + 1], 8'hEF);
        check("hs_stall", mw[t + 2], 0);
        check("hs_wr1", mw[t + 3], 1);
        check("hs_addr1", ma[t + 3], 32'h00030000);
        check("hs_data1", md[t + 3], 8'hBE);
        check("hs_dd", dd[t + 4], 1);

        // Reset in the middle of an ifetch, then refetch.
        next_cycle();
        instrAddr = 28'h0000124; instrMiss = 1'b1;
        t = cyc;
        run_until(t + 9);
        resetIn = 1'b0;
        next_cycle();
        resetIn = 1'b1;
        t2 = cyc;
        run_until(t2 + 19);
        instrMiss = 1'b0;
        next_cycle();
        check("mr_addr7", ma[t + 8], 32'h1247);
        check("mr_addr_rst", ma[t2], 0);
        check("mr_idat_rst", idat[t2], 0);
        check("mr_iv_none", count_hi(0, t, t2 + 17), 0);
        check("mr_addr0", ma[t2 + 1], 32'h1240);
        check("mr_iv", iv[t2 + 18], 1);
        check("mr_iadr", iadr[t2 + 18], 28'h0000124);
        check("mr_idat", idat[t2 + 18], 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        check("mr_dd_none", count_hi(1, t, t2 + 19), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
